// File: rtl/adpll_gain_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : adpll_gain_scheduler
// Brief    : Sequences the 2x2 NetworkADPLL array from wide-gain acquisition
//            to narrow-gain tracking, monitors per-node phase error for loss
//            of lock, and drives the shared enable/kp/ki words.
// Revision : 1.0 - initial release
// ============================================================================
module adpll_gain_scheduler #(
    parameter int PDET_WIDTH  = 8,
    parameter int KP_WIDTH    = 6,
    parameter int KI_WIDTH    = 9,
    parameter int CNT_WIDTH   = 16,
    parameter int LOCK_THR    = 4,
    parameter int UNLOCK_THR  = 16,
    parameter int LOCK_CNT    = 64,
    parameter int UNLOCK_CNT  = 8,
    parameter int ACQ_TIMEOUT = 4096
) (
    input  logic                    fpga_clk_i,
    input  logic                    reset_i,
    input  logic                    start_i,
    input  logic                    sample_i,
    input  logic [4*PDET_WIDTH-1:0] error_i,
    input  logic [KP_WIDTH-1:0]     kp_acq_i,
    input  logic [KI_WIDTH-1:0]     ki_acq_i,
    input  logic [KP_WIDTH-1:0]     kp_trk_i,
    input  logic [KI_WIDTH-1:0]     ki_trk_i,
    output logic                    enable_o,
    output logic [KP_WIDTH-1:0]     kp_o,
    output logic [KI_WIDTH-1:0]     ki_o,
    output logic                    locked_o,
    output logic                    fault_o,
    output logic [1:0]              state_o,
    output logic [CNT_WIDTH-1:0]    relock_cnt_o
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_ACQUIRE = 2'b01,
        ST_TRACK   = 2'b10,
        ST_FAULT   = 2'b11
    } state_t;

    // Magnitude saturation: the most negative code has no positive twin.
    localparam logic [PDET_WIDTH-1:0] c_most_neg   = {1'b1, {(PDET_WIDTH-1){1'b0}}};
    localparam logic [PDET_WIDTH-1:0] c_max_pos    = {1'b0, {(PDET_WIDTH-1){1'b1}}};
    localparam logic [PDET_WIDTH-1:0] c_lock_thr   = PDET_WIDTH'(LOCK_THR);
    localparam logic [PDET_WIDTH-1:0] c_unlock_thr = PDET_WIDTH'(UNLOCK_THR);
    localparam logic [CNT_WIDTH-1:0]  c_lock_cnt   = CNT_WIDTH'(LOCK_CNT);
    localparam logic [CNT_WIDTH-1:0]  c_unlock_cnt = CNT_WIDTH'(UNLOCK_CNT);
    localparam logic [CNT_WIDTH-1:0]  c_acq_tmo    = CNT_WIDTH'(ACQ_TIMEOUT);
    localparam logic                  c_tmo_en     = (ACQ_TIMEOUT != 0);

    // Registered state, counters and outputs
    state_t                r_state;
    logic [CNT_WIDTH-1:0]  r_lock_ctr;
    logic [CNT_WIDTH-1:0]  r_tmo_ctr;
    logic [CNT_WIDTH-1:0]  r_unl_ctr;
    logic [CNT_WIDTH-1:0]  r_relock_cnt;
    logic                  r_enable;
    logic [KP_WIDTH-1:0]   r_kp;
    logic [KI_WIDTH-1:0]   r_ki;
    logic                  r_locked;
    logic                  r_fault;

    // Next-state values
    state_t                w_state_nxt;
    logic [CNT_WIDTH-1:0]  w_lock_nxt;
    logic [CNT_WIDTH-1:0]  w_tmo_nxt;
    logic [CNT_WIDTH-1:0]  w_unl_nxt;
    logic [CNT_WIDTH-1:0]  w_relock_nxt;

    // Saturating increments of each counter
    logic [CNT_WIDTH-1:0]  w_lock_inc;
    logic [CNT_WIDTH-1:0]  w_tmo_inc;
    logic [CNT_WIDTH-1:0]  w_unl_inc;
    logic [CNT_WIDTH-1:0]  w_relock_inc;

    // Error magnitude
    logic [PDET_WIDTH-1:0] w_node_mag [4];
    logic [PDET_WIDTH-1:0] w_mag;
    logic                  w_lock_done;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign w_lock_inc   = sat_inc(r_lock_ctr);
    assign w_tmo_inc    = sat_inc(r_tmo_ctr);
    assign w_unl_inc    = sat_inc(r_unl_ctr);
    assign w_relock_inc = sat_inc(r_relock_cnt);

    // Per-node |err|, with the most negative code clamped to the max positive.
    generate
        for (genvar g = 0; g < 4; g++) begin : g_node
            logic [PDET_WIDTH-1:0] w_err;
            logic [PDET_WIDTH-1:0] w_neg;
            assign w_err = error_i[g*PDET_WIDTH +: PDET_WIDTH];
            assign w_neg = ~w_err + 1'b1;
            assign w_node_mag[g] = (w_err == c_most_neg)     ? c_max_pos :
                                   w_err[PDET_WIDTH-1]       ? w_neg     : w_err;
        end
    endgenerate

    // Largest magnitude over the four nodes
    always_comb begin
        w_mag = w_node_mag[0];
        for (int n = 1; n < 4; n++) begin
            if (w_node_mag[n] > w_mag) begin
                w_mag = w_node_mag[n];
            end
        end
    end

    // Next-state and counter update; counters move only on sample strobes
    always_comb begin
        w_state_nxt  = r_state;
        w_lock_nxt   = r_lock_ctr;
        w_tmo_nxt    = r_tmo_ctr;
        w_unl_nxt    = r_unl_ctr;
        w_relock_nxt = r_relock_cnt;
        w_lock_done  = 1'b0;

        if (!start_i) begin
            w_state_nxt = ST_IDLE;
            w_lock_nxt  = '0;
            w_tmo_nxt   = '0;
            w_unl_nxt   = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_state_nxt = ST_ACQUIRE;
                    w_lock_nxt  = '0;
                    w_tmo_nxt   = '0;
                    w_unl_nxt   = '0;
                end
                ST_ACQUIRE: begin
                    if (sample_i) begin
                        w_tmo_nxt = w_tmo_inc;
                        if (w_mag <= c_lock_thr) begin
                            w_lock_nxt = w_lock_inc;
                            if (w_lock_inc >= c_lock_cnt) begin
                                w_lock_done = 1'b1;
                            end
                        end else begin
                            w_lock_nxt = '0;
                        end
                        // Lock takes precedence when both complete on one sample
                        if (w_lock_done) begin
                            w_state_nxt = ST_TRACK;
                            w_lock_nxt  = '0;
                            w_tmo_nxt   = '0;
                            w_unl_nxt   = '0;
                        end else if (c_tmo_en && (w_tmo_inc >= c_acq_tmo)) begin
                            w_state_nxt = ST_FAULT;
                        end
                    end
                end
                ST_TRACK: begin
                    if (sample_i) begin
                        if (w_mag > c_unlock_thr) begin
                            w_unl_nxt = w_unl_inc;
                            if (w_unl_inc >= c_unlock_cnt) begin
                                w_state_nxt  = ST_ACQUIRE;
                                w_relock_nxt = w_relock_inc;
                                w_lock_nxt   = '0;
                                w_tmo_nxt    = '0;
                                w_unl_nxt    = '0;
                            end
                        end else begin
                            w_unl_nxt = '0;
                        end
                    end
                end
                ST_FAULT: begin
                    w_state_nxt = ST_FAULT;
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // State and counter registers
    always_ff @(posedge fpga_clk_i) begin
        if (reset_i) begin
            r_state      <= ST_IDLE;
            r_lock_ctr   <= '0;
            r_tmo_ctr    <= '0;
            r_unl_ctr    <= '0;
            r_relock_cnt <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_lock_ctr   <= w_lock_nxt;
            r_tmo_ctr    <= w_tmo_nxt;
            r_unl_ctr    <= w_unl_nxt;
            r_relock_cnt <= w_relock_nxt;
        end
    end

    // Output registers decoded from the next state so they align with state_o
    always_ff @(posedge fpga_clk_i) begin
        if (reset_i) begin
            r_enable <= 1'b0;
            r_kp     <= '0;
            r_ki     <= '0;
            r_locked <= 1'b0;
            r_fault  <= 1'b0;
        end else begin
            r_enable <= (w_state_nxt == ST_ACQUIRE) || (w_state_nxt == ST_TRACK);
            r_kp     <= (w_state_nxt == ST_TRACK) ? kp_trk_i : kp_acq_i;
            r_ki     <= (w_state_nxt == ST_TRACK) ? ki_trk_i : ki_acq_i;
            r_locked <= (w_state_nxt == ST_TRACK);
            r_fault  <= (w_state_nxt == ST_FAULT);
        end
    end

    assign enable_o     = r_enable;
    assign kp_o         = r_kp;
    assign ki_o         = r_ki;
    assign locked_o     = r_locked;
    assign fault_o      = r_fault;
    assign state_o      = r_state;
    assign relock_cnt_o = r_relock_cnt;

endmodule
`default_nettype wire
